// File: rtl/core_pkg.sv
// core_pkg: shared constants and control bundle for the 5-stage RV64 core.
package core_pkg;
    localparam int XLEN = 64;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    typedef struct packed {
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic [1:0] alu_op;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
    } ctrl_t;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use stall; a pending flush overrides it.
module hazard_detect (
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_alu_src,
    input  logic       id_mem_write,
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       flush,
    output logic       stall
);
    logic uses_rs2;
    always_comb begin
        uses_rs2 = !id_alu_src || id_mem_write;
        stall = !flush && id_valid && ex_valid && ex_mem_read && ex_rd != 5'd0 &&
                (ex_rd == id_rs1 || (uses_rs2 && ex_rd == id_rs2));
    end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion,
// flush squash and a saturating bubble counter.
module id_ex_stage #(
    parameter int XLEN  = core_pkg::XLEN,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic             id_branch,
    input  logic             id_MemRead,
    input  logic             id_MemToReg,
    input  logic [1:0]       id_ALUOp,
    input  logic             id_MemWrite,
    input  logic             id_ALUSrc,
    input  logic             id_RegWrite,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [XLEN-1:0]  id_read_data1,
    input  logic [XLEN-1:0]  id_read_data2,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [3:0]       id_funct4,
    input  logic             flush,
    output logic             ex_valid,
    output logic             ex_branch,
    output logic             ex_MemRead,
    output logic             ex_MemToReg,
    output logic [1:0]       ex_ALUOp,
    output logic             ex_MemWrite,
    output logic             ex_ALUSrc,
    output logic             ex_RegWrite,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [XLEN-1:0]  ex_read_data1,
    output logic [XLEN-1:0]  ex_read_data2,
    output logic [XLEN-1:0]  ex_imm,
    output logic [XLEN-1:0]  ex_pc,
    output logic [3:0]       ex_funct4,
    output logic             stall,
    output logic             pc_write,
    output logic             ifid_write,
    output logic [CNT_W-1:0] bubble_count
);
    import core_pkg::*;

    ctrl_t            id_ctrl, ctrl_d, ctrl_q;
    logic             valid_d, valid_q, bubble;
    logic [4:0]       rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
    logic [XLEN-1:0]  rd1_d, rd1_q, rd2_d, rd2_q, imm_d, imm_q, pc_d, pc_q;
    logic [3:0]       funct4_d, funct4_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    hazard_detect u_hazard (
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_alu_src  (id_ALUSrc),
        .id_mem_write(id_MemWrite),
        .ex_valid    (valid_q),
        .ex_mem_read (ctrl_q.mem_read),
        .ex_rd       (rd_q),
        .flush       (flush),
        .stall       (stall)
    );

    always_comb begin
        id_ctrl  = '{id_branch, id_MemRead, id_MemToReg, id_ALUOp, id_MemWrite, id_ALUSrc, id_RegWrite};
        bubble   = flush || stall;
        valid_d  = bubble ? 1'b0 : id_valid;
        ctrl_d   = (bubble || !id_valid) ? '0 : id_ctrl;
        rs1_d    = bubble ? '0 : id_rs1;
        rs2_d    = bubble ? '0 : id_rs2;
        rd_d     = bubble ? '0 : id_rd;
        rd1_d    = bubble ? '0 : id_read_data1;
        rd2_d    = bubble ? '0 : id_read_data2;
        imm_d    = bubble ? '0 : id_imm;
        pc_d     = bubble ? '0 : id_pc;
        funct4_d = bubble ? '0 : id_funct4;
        // only a squashed or held real instruction counts as a bubble
        cnt_d    = (bubble && id_valid && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            rd1_q    <= '0;
            rd2_q    <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
            funct4_q <= '0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            imm_q    <= imm_d;
            pc_q     <= pc_d;
            funct4_q <= funct4_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_branch     = ctrl_q.branch;
    assign ex_MemRead    = ctrl_q.mem_read;
    assign ex_MemToReg   = ctrl_q.mem_to_reg;
    assign ex_ALUOp      = ctrl_q.alu_op;
    assign ex_MemWrite   = ctrl_q.mem_write;
    assign ex_ALUSrc     = ctrl_q.alu_src;
    assign ex_RegWrite   = ctrl_q.reg_write;
    assign ex_rs1        = rs1_q;
    assign ex_rs2        = rs2_q;
    assign ex_rd         = rd_q;
    assign ex_read_data1 = rd1_q;
    assign ex_read_data2 = rd2_q;
    assign ex_imm        = imm_q;
    assign ex_pc         = pc_q;
    assign ex_funct4     = funct4_q;
    assign pc_write      = !stall;
    assign ifid_write    = !stall;
    assign bubble_count  = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage; a reference model of the
// pipeline slot predicts each cycle's outputs, a monitor compares at negedge.
module tb_id_ex_stage;
    import core_pkg::*;
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] CMAX = '1;

    typedef struct packed {
        logic        valid, branch, mem_read, mem_to_reg;
        logic [1:0]  alu_op;
        logic        mem_write, alu_src, reg_write;
        logic [4:0]  rs1, rs2, rd;
        logic [63:0] d1, d2, imm, pc;
        logic [3:0]  f4;
    } slot_t;
    typedef struct packed {
        slot_t            ex;
        logic             stall;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 0, reset = 1;
    logic id_valid, id_branch, id_MemRead, id_MemToReg, id_MemWrite, id_ALUSrc, id_RegWrite, flush;
    logic [1:0] id_ALUOp, ex_ALUOp;
    logic [4:0] id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2, ex_rd;
    logic [63:0] id_read_data1, id_read_data2, id_imm, id_pc;
    logic [63:0] ex_read_data1, ex_read_data2, ex_imm, ex_pc;
    logic [3:0] id_funct4, ex_funct4;
    logic ex_valid, ex_branch, ex_MemRead, ex_MemToReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite;
    logic stall, pc_write, ifid_write;
    logic [CNT_W-1:0] bubble_count;

    id_ex_stage #(.XLEN(64), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_branch(id_branch),
        .id_MemRead(id_MemRead), .id_MemToReg(id_MemToReg), .id_ALUOp(id_ALUOp),
        .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc), .id_RegWrite(id_RegWrite),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_read_data1(id_read_data1),
        .id_read_data2(id_read_data2), .id_imm(id_imm), .id_pc(id_pc), .id_funct4(id_funct4),
        .flush(flush), .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_MemRead(ex_MemRead),
        .ex_MemToReg(ex_MemToReg), .ex_ALUOp(ex_ALUOp), .ex_MemWrite(ex_MemWrite),
        .ex_ALUSrc(ex_ALUSrc), .ex_RegWrite(ex_RegWrite), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_read_data1(ex_read_data1), .ex_read_data2(ex_read_data2),
        .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_funct4(ex_funct4), .stall(stall),
        .pc_write(pc_write), .ifid_write(ifid_write), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int checks = 0, fails = 0;
    slot_t cur, mex;
    bit cur_fl;
    logic [CNT_W-1:0] mcnt;

    function automatic bit hazard(slot_t id, slot_t ex, bit fl);
        bit uses_rs2 = !id.alu_src || id.mem_write;
        return !fl && id.valid && ex.valid && ex.mem_read && ex.rd != 0 &&
               (ex.rd == id.rs1 || (uses_rs2 && ex.rd == id.rs2));
    endfunction

    // one clock edge of the pipeline slot as seen from outside
    function void model_edge();
        if (cur_fl || hazard(cur, mex, 0)) begin
            if (cur.valid && mcnt != CMAX) mcnt = mcnt + 1'b1;
            mex = '0;
        end else begin
            mex = cur;
            if (!cur.valid) {mex.branch, mex.mem_read, mex.mem_to_reg, mex.alu_op,
                             mex.mem_write, mex.alu_src, mex.reg_write} = '0;
        end
    endfunction

    function automatic slot_t instr(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
        slot_t s = '0;
        s.valid = 1; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2;
        s.d1 = {$urandom, $urandom}; s.d2 = {$urandom, $urandom};
        s.imm = {$urandom, $urandom}; s.pc = {$urandom, $urandom}; s.f4 = 4'($urandom);
        case (op)
            OP_R:    begin s.alu_op = ALUOP_FUNCT; s.reg_write = 1; end
            OP_LD:   begin s.mem_read = 1; s.mem_to_reg = 1; s.reg_write = 1; s.alu_src = 1; end
            OP_SD:   begin s.mem_write = 1; s.alu_src = 1; end
            OP_BEQ:  begin s.branch = 1; s.alu_op = ALUOP_BR; end
            default: begin s.alu_src = 1; s.reg_write = 1; end
        endcase
        return s;
    endfunction

    function automatic slot_t rand_stim();
        logic [6:0] op;
        slot_t s;
        case ($urandom_range(0, 4))
            0: op = OP_R;
            1: op = OP_LD;
            2: op = OP_SD;
            3: op = OP_BEQ;
            default: op = OP_ADDI;
        endcase
        s = instr(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        if ($urandom_range(0, 3) == 0)
            {s.branch, s.mem_read, s.mem_to_reg, s.alu_op, s.mem_write, s.alu_src, s.reg_write} = 8'($urandom);
        s.valid = $urandom_range(0, 7) != 0;
        return s;
    endfunction

    task automatic drive();
        id_valid = cur.valid; id_branch = cur.branch; id_MemRead = cur.mem_read;
        id_MemToReg = cur.mem_to_reg; id_ALUOp = cur.alu_op; id_MemWrite = cur.mem_write;
        id_ALUSrc = cur.alu_src; id_RegWrite = cur.reg_write; id_rs1 = cur.rs1; id_rs2 = cur.rs2;
        id_rd = cur.rd; id_read_data1 = cur.d1; id_read_data2 = cur.d2; id_imm = cur.imm;
        id_pc = cur.pc; id_funct4 = cur.f4; flush = cur_fl;
    endtask

    task automatic push_exp();
        exp_t e;
        e.ex = mex; e.stall = hazard(cur, mex, cur_fl); e.cnt = mcnt;
        q.push_back(e);
    endtask

    task automatic step(input slot_t s, input bit fl);
        @(posedge clk);
        if (!reset) model_edge();
        #1;
        cur = s; cur_fl = fl;
        drive();
        push_exp();
    endtask

    task automatic mid_reset();
        @(posedge clk);
        model_edge();
        #2;
        reset = 1; mex = '0; mcnt = '0;
        push_exp();
        @(negedge clk);
        #1 reset = 0;
    endtask

    initial begin : monitor
        exp_t e;
        slot_t a;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                a = '{ex_valid, ex_branch, ex_MemRead, ex_MemToReg, ex_ALUOp, ex_MemWrite, ex_ALUSrc,
                      ex_RegWrite, ex_rs1, ex_rs2, ex_rd, ex_read_data1, ex_read_data2, ex_imm, ex_pc, ex_funct4};
                checks += 4;
                if (a !== e.ex) begin
                    fails++;
                    $display("FAIL ex_regs t=%0t got=%h exp=%h", $time, a, e.ex);
                end
                if (stall !== e.stall) begin
                    fails++;
                    $display("FAIL stall t=%0t got=%b exp=%b", $time, stall, e.stall);
                end
                if (pc_write !== !e.stall || ifid_write !== !e.stall) begin
                    fails++;
                    $display("FAIL write_en t=%0t got pc_write=%b ifid_write=%b exp=%b", $time, pc_write, ifid_write, !e.stall);
                end
                if (bubble_count !== e.cnt) begin
                    fails++;
                    $display("FAIL bubble_count t=%0t got=%0d exp=%0d", $time, bubble_count, e.cnt);
                end
            end
        end
    end

    initial begin : driver
        slot_t idle, ld7, ld0, add7, add0, addi, sd7, r5;
        idle = '0; mex = '0; mcnt = '0; cur = '0; cur_fl = 0;
        drive();
        step(idle, 0);
        @(negedge clk);
        #1 reset = 0;
        ld7  = instr(OP_LD, 7, 2, 0);
        ld0  = instr(OP_LD, 0, 2, 0);
        add7 = instr(OP_R, 8, 7, 3);
        add0 = instr(OP_R, 8, 0, 3);
        addi = instr(OP_ADDI, 9, 3, 7);
        sd7  = instr(OP_SD, 0, 2, 7);
        r5   = instr(OP_R, 5, 1, 2);
        r5.d1 = 64'h10; r5.d2 = 64'h20;
        step(r5, 0);   step(idle, 0);
        step(ld7, 0);  step(add7, 0); step(add7, 0); step(idle, 0);
        step(ld0, 0);  step(add0, 0); step(idle, 0);
        step(ld7, 0);  step(addi, 0); step(idle, 0);
        step(ld7, 0);  step(sd7, 0);  step(sd7, 0);  step(idle, 0);
        step(ld7, 0);  step(add7, 1); step(idle, 0);
        idle.rs1 = 7; idle.rd = 3;
        step(ld7, 0);  step(idle, 1); step(idle, 0);
        step(ld7, 0);  step(add7, 0);
        mid_reset();
        step(idle, 0);
        repeat (40) step(rand_stim(), 1);
        step(ld7, 0);  step(add7, 0); step(idle, 0);
        mid_reset();
        repeat (400) step(rand_stim(), $urandom_range(0, 9) == 0);
        step(idle, 0);
        repeat (2) @(negedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage RV64 core, directly downstream of the main decoder's control outputs.
- Latches decoded control signals, register operands, immediate and PC into the EX stage.
- Detects load-use hazards and inserts one bubble while stalling PC and IF/ID.
- Squashes the decode-stage instruction when a taken branch is signalled. Also keeps a saturating bubble counter for debug.

Parameters:
XLEN, 64, datapath width (operands, immediate, PC)
CNT_W, 16, width of saturating bubble counter

Ports:
clk  input  1  core clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
id_valid  input  1  decode stage holds a real instruction
id_branch  input  1  decoder control: branch
id_MemRead  input  1  decoder control: memory read
id_MemToReg  input  1  decoder control: writeback select
id_ALUOp  input  2  decoder control: ALU op class
id_MemWrite  input  1  decoder control: memory write
id_ALUSrc  input  1  decoder control: ALU B-source select
id_RegWrite  input  1  decoder control: register write
id_rs1  input  5  source register 1 index
id_rs2  input  5  source register 2 index
id_rd  input  5  destination register index
id_read_data1  input  XLEN  register file port 1
id_read_data2  input  XLEN  register file port 2
id_imm  input  XLEN  sign-extended immediate
id_pc  input  XLEN  PC of decode instruction
id_funct4  input  4  {instr[30], instr[14:12]} for ALU control
flush  input  1  taken branch resolved downstream; squash decode instruction
ex_valid, ex_branch, ex_MemRead, ex_MemToReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite  output  1 each  registered copies
ex_ALUOp  output  2  registered copy
ex_rs1, ex_rs2, ex_rd  output  5 each  registered copies
ex_read_data1, ex_read_data2, ex_imm, ex_pc  output  XLEN each  registered copies
ex_funct4  output  4  registered copy
stall  output  1  combinational load-use hazard indication
pc_write  output  1  combinational, = ~stall
ifid_write  output  1  combinational, = ~stall
bubble_count  output  CNT_W  bubbles inserted since reset, saturating

Behaviour:
- Reset (async, active-high):
  - all ex_* outputs go to 0 immediately, including ex_valid=0, ex_ALUOp=2'b00, data fields 0.
  - bubble_count=0.
  - stall, pc_write and ifid_write follow their equations. With ex_MemRead=0 this gives stall=0 and pc_write=ifid_write=1.
- Hazard (combinational, from current EX contents and ID inputs):
  - uses_rs2 = id_ALUSrc==0 OR id_MemWrite==1.
  - stall = id_valid AND ex_valid AND ex_MemRead AND ex_rd!=0 AND (ex_rd==id_rs1 OR (uses_rs2 AND ex_rd==id_rs2)).
  - flush forces stall=0, so pc_write=ifid_write=1.
- Clock edge, in priority order:
  1. flush=1: load bubble. All control outputs=0, ex_valid=0, data fields=0. The hazard is ignored.
  2. stall=1: load bubble (same as flush). Upstream holds, so the same ID instruction is re-presented next cycle. Exactly one bubble is inserted per load-use.
  3. Otherwise: capture every id_* field.
     - ex_valid = id_valid.
     - When id_valid=0, control outputs are forced to 0; data fields are still captured.
- Bubble counter:
  - increments by 1 on each edge where case 1 or 2 applies and the squashed or held ID instruction had id_valid=1.
  - saturates at all-ones with no wrap.
- Latency: 1 cycle from ID inputs to ex_* outputs. stall has zero-cycle latency.
- Edge cases:
  - No false stall on x0: ex_rd=0 never stalls.
  - A load followed by a store using the load result as store data stalls (uses_rs2 via MemWrite).
  - Reset mid-stall clears the EX load, so stall drops immediately.

Decomposition:
- Shared package core_pkg holds:
  - opcode constants OP_R=7'b0110011, OP_LD=7'b0000011, OP_SD=7'b0100011, OP_BEQ=7'b1100011, OP_ADDI=7'b0010011.
  - ALUOp encodings ALUOP_ADD=2'b00, ALUOP_BR=2'b01, ALUOP_FUNCT=2'b10.
  - XLEN default.
- One sub-module, hazard_detect, is the purely combinational stall equation. The register and counter stay in id_ex_stage.

Test Plan:
- Reset: assert reset mid-cycle with ex state loaded -> all ex_* = 0 at once, bubble_count=0, stall=0, pc_write=1.
- Pass-through: R-type, id_rd=5, data1=0x10, data2=0x20, ALUOp=2'b10, RegWrite=1 -> next cycle ex_rd=5, ex_read_data1=0x10, ex_ALUOp=2'b10, ex_valid=1.
- Load-use: ld with rd=7 in EX, then add with rs1=7 in ID -> stall=1, pc_write=0, ifid_write=0. Next edge gives a bubble (ex_valid=0, ex_RegWrite=0) and bubble_count=1. Next cycle stall=0 and the add is captured.
- No false stalls:
  - ld rd=0, then add rs1=0 -> stall=0.
  - ld rd=7, then addi rs1=3, rs2 field=7 -> stall=0.
  - ld rd=7, then sd rs2=7 -> stall=1.
- Flush priority: flush=1 with a simultaneous load-use hazard -> stall=0, bubble loaded, bubble_count+1. With flush=1 and id_valid=0 -> bubble loaded, count unchanged.
- Saturation: force bubble_count to 0xFFFF, trigger a stall -> count stays 0xFFFF.
